sram22_req_ctrl: RTL
====================

SRAM22_REQ_CTRL -- requirements
Module: sram22_req_ctrl

Interface
REQ-001 Parameters: DATA_WIDTH, 32, data word width; ADDR_WIDTH, 11, word address width; WMASK_WIDTH, 4, byte-lane mask width (DATA_WIDTH/8); RSP_DEPTH, 2, response buffer entries.
REQ-002 One clock; reset is synchronous and active-high; ports clk and rst.
REQ-003 clk  in  1  clock; all state changes on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request offered; req_ready  out  1  request accepted when both high (fire).
REQ-006 req_we  in  1  write when 1, read when 0; req_wmask  in  WMASK_WIDTH  byte enables; req_addr  in  ADDR_WIDTH  word address; req_din  in  DATA_WIDTH  write data.
REQ-007 rsp_valid  out  1  response available; rsp_ready  in  1  response consumed when both high (pop); rsp_dout  out  DATA_WIDTH  response data.
REQ-008 sram_we  out  1; sram_wmask  out  WMASK_WIDTH; sram_addr  out  ADDR_WIDTH; sram_din  out  DATA_WIDTH; sram_dout  in  DATA_WIDTH: single-port macro interface, read data valid one cycle after a read edge.

Function
REQ-009 sram_addr, sram_wmask and sram_din shall equal req_addr, req_wmask and req_din combinationally.
REQ-010 sram_we shall equal req_valid & req_ready & req_we; any non-write cycle is a macro read.
REQ-011 A read fire shall set flag pend for exactly the next cycle; in that cycle sram_dout shall be written into the response FIFO.
REQ-012 The response FIFO shall be RSP_DEPTH entries, in-order, with count 0..RSP_DEPTH; push and pop in the same cycle leave count unchanged.
REQ-013 rsp_valid shall be (count != 0); rsp_dout shall be the head entry, unchanged while rsp_valid & !rsp_ready.
REQ-014 req_ready shall be 1 iff !rst and (count + pend - pop) < RSP_DEPTH; the rsp_ready-to-req_ready combinational path is intended.
REQ-015 Read latency: request fire in cycle N gives rsp_valid high in cycle N+2 at the earliest; with rsp_ready held high, one read shall be accepted per cycle indefinitely.
REQ-016 The FIFO shall never overflow; a push into a full FIFO is a design error, to be flagged by a simulation assertion.
REQ-017 A pop with count==0 shall be ignored.
REQ-018 Writes shall follow REQ-025/026; write data never appears on rsp_dout.

Reset
REQ-019 While rst is high: req_ready=0, sram_we=0.
REQ-020 After a reset edge: count=0, pend=0, FIFO pointers=0, rsp_valid=0, rsp_dout=0.
REQ-021 A read accepted in the cycle before reset asserts, or with reset asserted in its pend cycle, shall be dropped with no response.
REQ-022 The first request may be accepted in the first cycle with rst low.

Configuration
REQ-023 Macro SRAM22_REQ_CTRL_WRITE_ACK_EN selects write acknowledgement.
REQ-024 The macro changes no ports or parameters.
REQ-025 With the macro defined, a write fire shall set pend and push an all-zero entry the next cycle, and shall count against REQ-014 credit like a read.
REQ-026 With the macro undefined, writes shall produce no response, set no pend, and shall be accepted whenever (count + pend - pop) < RSP_DEPTH.

Verification
REQ-027 Write addr 0x005, wmask 4'b0101, din 0xAABBCCDD into zeroed memory, then read 0x005 -> rsp_dout 0x00BB00DD two cycles after the read fire.
REQ-028 rsp_ready held 0, reads issued to 0x001..0x004 -> exactly 2 accepted; req_ready low from then on; rsp_dout holds the first word; raising rsp_ready drains both in order, then req_ready returns high.
REQ-029 rsp_ready held 1, 16 back-to-back reads -> req_ready never drops, 16 responses in order on consecutive cycles.
REQ-030 rst asserted one cycle after a read fire -> no response ever appears; rsp_valid=0 and count=0 after reset.
REQ-031 Write then read, same address, with and without SRAM22_REQ_CTRL_WRITE_ACK_EN -> defined: two responses (0x00000000, then the data); undefined: one response (the data).

Source files
------------

// File: rtl/sram22_req_ctrl.sv
// Request/response front end for a single-port SRAM macro with a credit-checked response FIFO.
// Optional write acknowledgement: define SRAM22_REQ_CTRL_WRITE_ACK_EN.
module sram22_req_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned WMASK_WIDTH = 4,
  parameter int unsigned RSP_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_din,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_dout,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  pend_q;

  logic                  fire, pend_set, push, pop;
  logic [CntW:0]         credit_used;
  logic [DATA_WIDTH-1:0] push_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fire = req_valid & req_ready;
  assign push = pend_q;
  assign pop  = rsp_ready & (count_q != '0);

`ifdef SRAM22_REQ_CTRL_WRITE_ACK_EN
  logic pend_we_q;
  assign pend_set  = fire;
  assign push_data = pend_we_q ? '0 : sram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_we_q <= 1'b0;
    end else begin
      pend_we_q <= fire & req_we;
    end
  end
`else
  assign pend_set  = fire & ~req_we;
  assign push_data = sram_dout;
`endif

  // Entries already held plus the one landing next cycle, less the one leaving now.
  always_comb begin
    credit_used = {1'b0, count_q} + (CntW + 1)'(pend_q) - (CntW + 1)'(pop);
    req_ready   = ~rst & (credit_used < (CntW + 1)'(RSP_DEPTH));
  end

  assign sram_we    = fire & req_we;
  assign sram_wmask = req_wmask;
  assign sram_addr  = req_addr;
  assign sram_din   = req_din;

  assign rsp_valid = (count_q != '0);
  assign rsp_dout  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_set;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Credit accounting should make this unreachable.
  assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CntW'(RSP_DEPTH)) && !pop));

endmodule
